key_filter: RTL

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/key_filter.sv
// Push-button debouncer: two-flop synchroniser, edge detect and a four-state filter FSM
// that emits one-cycle press/release strobes once the level holds for CNT_MAX cycles.
module key_filter #(
    parameter int unsigned CNT_MAX = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    localparam logic [1:0] StIdle       = 2'd0;
    localparam logic [1:0] StFilterDown = 2'd1;
    localparam logic [1:0] StDown       = 2'd2;
    localparam logic [1:0] StFilterUp   = 2'd3;

    logic          r_key_s1;
    logic          r_key_sync;
    logic          r_key_d;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_key_state;
    logic          r_press;
    logic          r_release;

    logic          w_neg_edge;
    logic          w_pos_edge;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_key_state_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;

    assign w_neg_edge = r_key_d & ~r_key_sync;
    assign w_pos_edge = ~r_key_d & r_key_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_s1   <= 1'b1;
            r_key_sync <= 1'b1;
            r_key_d    <= 1'b1;
        end else begin
            r_key_s1   <= key_in;
            r_key_sync <= r_key_s1;
            r_key_d    <= r_key_sync;
        end
    end

    // An edge seen on the terminal-count cycle is treated as bounce: edge checks come first.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_key_state_nxt = r_key_state;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (w_neg_edge) begin
                    w_state_nxt = StFilterDown;
                end
            end
            StFilterDown: begin
                if (w_pos_edge) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = StDown;
                    w_cnt_nxt       = '0;
                    w_key_state_nxt = 1'b0;
                    w_press_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StDown: begin
                w_cnt_nxt = '0;
                if (w_pos_edge) begin
                    w_state_nxt = StFilterUp;
                end
            end
            StFilterUp: begin
                if (w_neg_edge) begin
                    w_state_nxt = StDown;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = StIdle;
                    w_cnt_nxt       = '0;
                    w_key_state_nxt = 1'b1;
                    w_release_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt     = StIdle;
                w_cnt_nxt       = '0;
                w_key_state_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_key_state <= 1'b1;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_state <= w_key_state_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
        end
    end

    assign key_state     = r_key_state;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule
